// File: rtl/bbs_bit_packer_if.sv
// Bus bundle for the BBS bit packer.
// The slave side is the packer; the master side feeds bits and consumes words.
// Optional BBS_PACKER_MONOBIT_EN adds the ones_count signal.
interface bbs_bit_packer_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4
);
    logic                     start;
    logic                     bit_in;
    logic                     bit_valid;
    logic [W-1:0]             word_out;
    logic                     word_valid;
    logic                     word_ready;
    logic [$clog2(DEPTH):0]   words_avail;
    logic                     overflow;
`ifdef BBS_PACKER_MONOBIT_EN
    logic [15:0]              ones_count;

    modport master (
        output start, bit_in, bit_valid, word_ready,
        input  word_out, word_valid, words_avail, overflow, ones_count
    );

    modport slave (
        input  start, bit_in, bit_valid, word_ready,
        output word_out, word_valid, words_avail, overflow, ones_count
    );
`else
    modport master (
        output start, bit_in, bit_valid, word_ready,
        input  word_out, word_valid, words_avail, overflow
    );

    modport slave (
        input  start, bit_in, bit_valid, word_ready,
        output word_out, word_valid, words_avail, overflow
    );
`endif
endinterface

// File: rtl/bbs_bit_packer.sv
// BBS bit packer: deserialises accepted random bits into W-bit words,
// buffers them in a show-ahead FIFO and flags words lost to back-pressure.
// Optional macro BBS_PACKER_MONOBIT_EN adds a saturating count of accepted ones.
module bbs_bit_packer #(
    parameter int W         = 32,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    bbs_bit_packer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_enter;
    logic                w_accept;

    logic [W-1:0]        r_sh;
    logic [W-1:0]        w_sh_next;
    logic [CW-1:0]       r_cnt;
    logic                w_last_bit;
    logic                w_word_done;

    logic [W-1:0]        r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                r_overflow;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is a level enable for collection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (bus.start)  w_next_state = S_COLLECT;
            S_COLLECT: if (!bus.start) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: entry pulse clears the datapath, acceptance only while collecting
    always_comb begin
        w_enter  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE:    w_enter  = bus.start;
            S_COLLECT: w_accept = bus.bit_valid;
            default:   ;
        endcase
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sh_next = {r_sh[W-2:0], bus.bit_in};
        end else begin : g_lsb_first
            assign w_sh_next = {bus.bit_in, r_sh[W-1:1]};
        end
    endgenerate

    assign w_last_bit  = (r_cnt == CW'(W - 1));
    assign w_word_done = w_accept && w_last_bit;

    // Shift register and bit counter; a stale partial word is wiped on re-entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_enter) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sh  <= w_sh_next;
            r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && bus.word_ready;
    assign w_push  = w_word_done && (!w_full || w_pop);
    assign w_drop  = w_word_done && w_full && !w_pop;

    // FIFO storage; the completed word is written straight from the shift path
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sh_next;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow, cleared only by reset or a fresh collection run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_enter) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.word_valid  = !w_empty;
    assign bus.word_out    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.words_avail = r_count;
    assign bus.overflow    = r_overflow;

`ifdef BBS_PACKER_MONOBIT_EN
    logic [15:0] r_ones;

    // Monobit tally over every accepted bit, including dropped or discarded ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ones <= '0;
        end else if (w_enter) begin
            r_ones <= '0;
        end else if (w_accept && bus.bit_in && (r_ones != 16'hFFFF)) begin
            r_ones <= r_ones + 1'b1;
        end
    end

    assign bus.ones_count = r_ones;
`endif

endmodule

// File: tb/tb_bbs_bit_packer.sv
// Testbench for bbs_bit_packer: scoreboard-checked word stream plus
// directed status checks. Exercises BBS_PACKER_MONOBIT_EN when defined.
module tb_bbs_bit_packer;

    logic clk;
    logic rst;
    logic lsbStart;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] expQ[$];
    logic [7:0] expQL[$];

    bbs_bit_packer_if #(.W(8), .DEPTH(2)) busM ();
    bbs_bit_packer_if #(.W(8), .DEPTH(2)) busL ();

    bbs_bit_packer #(.W(8), .DEPTH(2), .MSB_FIRST(1)) dutM (
        .clk (clk),
        .rst (rst),
        .bus (busM)
    );

    bbs_bit_packer #(.W(8), .DEPTH(2), .MSB_FIRST(0)) dutL (
        .clk (clk),
        .rst (rst),
        .bus (busL)
    );

    // The LSB-first instance shares the bit stream but only collects when enabled
    assign busL.start      = lsbStart;
    assign busL.bit_in     = busM.bit_in;
    assign busL.bit_valid  = busM.bit_valid;
    assign busL.word_ready = 1'b1;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendOneBit(input logic b);
        busM.bit_in    = b;
        busM.bit_valid = 1'b1;
        tick();
        busM.bit_valid = 1'b0;
    endtask

    // Sends the top nBits of v, most significant bit first, one bit per cycle
    task automatic applyStimulus(input logic [7:0] v, input int nBits);
        for (int i = 7; i > 7 - nBits; i--) begin
            sendOneBit(v[i]);
        end
    endtask

    // Scoreboard monitor for the MSB-first instance
    always @(negedge clk) begin
        if (rst === 1'b1 && busM.word_valid && busM.word_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL msbWord: got unexpected word %0h, expected none", busM.word_out);
            end else begin
                checkOutput("msbWord", 32'(busM.word_out), 32'(expQ.pop_front()));
            end
        end
    end

    // Scoreboard monitor for the LSB-first instance
    always @(negedge clk) begin
        if (rst === 1'b1 && busL.word_valid && busL.word_ready) begin
            if (expQL.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL lsbWord: got unexpected word %0h, expected none", busL.word_out);
            end else begin
                checkOutput("lsbWord", 32'(busL.word_out), 32'(expQL.pop_front()));
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus
    initial begin
        busM.start      = 1'b0;
        busM.bit_in     = 1'b0;
        busM.bit_valid  = 1'b0;
        busM.word_ready = 1'b0;
        lsbStart        = 1'b0;
        rst             = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rstValid", 32'(busM.word_valid), 32'd0);
        checkOutput("rstAvail", 32'(busM.words_avail), 32'd0);
        checkOutput("rstOverflow", 32'(busM.overflow), 32'd0);
        checkOutput("rstWordOut", 32'(busM.word_out), 32'd0);
`ifdef BBS_PACKER_MONOBIT_EN
        checkOutput("rstOnes", 32'(busM.ones_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Packing order in both bit orders
        busM.word_ready = 1'b1;
        busM.start      = 1'b1;
        lsbStart        = 1'b1;
        tick();
        expQ.push_back(8'hB2);
        expQL.push_back(8'h4D);
        applyStimulus(8'hB2, 8);
        checkOutput("packValid", 32'(busM.word_valid), 32'd1);
        checkOutput("packAvail", 32'(busM.words_avail), 32'd1);
        checkOutput("packLsbValid", 32'(busL.word_valid), 32'd1);
        tick();
        checkOutput("packValidOneCycle", 32'(busM.word_valid), 32'd0);
        checkOutput("packAvailDrained", 32'(busM.words_avail), 32'd0);
        lsbStart = 1'b0;

        // Back-pressure: third word is dropped
        busM.word_ready = 1'b0;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h3C);
        applyStimulus(8'hA5, 8);
        applyStimulus(8'h3C, 8);
        applyStimulus(8'hFF, 8);
        checkOutput("bpAvail", 32'(busM.words_avail), 32'd2);
        checkOutput("bpOverflow", 32'(busM.overflow), 32'd1);
        busM.word_ready = 1'b1;
        tick();
        tick();
        busM.word_ready = 1'b0;
        checkOutput("bpDrained", 32'(busM.words_avail), 32'd0);
        checkOutput("bpOverflowSticky", 32'(busM.overflow), 32'd1);

        // Full FIFO with a pop on the completing edge
        busM.start = 1'b0;
        tick();
        busM.start = 1'b1;
        tick();
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        expQ.push_back(8'h33);
        applyStimulus(8'h11, 8);
        applyStimulus(8'h22, 8);
        checkOutput("fullAvail", 32'(busM.words_avail), 32'd2);
        applyStimulus(8'h33, 7);
        busM.word_ready = 1'b1;
        sendOneBit(1'b1);
        busM.word_ready = 1'b0;
        checkOutput("fullPopAvail", 32'(busM.words_avail), 32'd2);
        checkOutput("fullPopOverflow", 32'(busM.overflow), 32'd0);
        busM.word_ready = 1'b1;
        tick();
        tick();
        busM.word_ready = 1'b0;
        checkOutput("fullPopDrained", 32'(busM.words_avail), 32'd0);

        // Start drop mid-word with stored words and overflow pending
        expQ.push_back(8'h5A);
        expQ.push_back(8'h6B);
        applyStimulus(8'h5A, 8);
        applyStimulus(8'h6B, 8);
        applyStimulus(8'h7C, 8);
        applyStimulus(8'hF0, 5);
        busM.start = 1'b0;
        tick();
        checkOutput("idleOverflowHeld", 32'(busM.overflow), 32'd1);
        applyStimulus(8'hFF, 3);
        checkOutput("idleAvailKept", 32'(busM.words_avail), 32'd2);
        busM.start     = 1'b1;
        busM.bit_in    = 1'b1;
        busM.bit_valid = 1'b1;
        tick();
        busM.bit_valid = 1'b0;
        checkOutput("reentryOverflow", 32'(busM.overflow), 32'd0);
        busM.word_ready = 1'b1;
        expQ.push_back(8'h81);
        applyStimulus(8'h81, 8);
        checkOutput("reentryValid", 32'(busM.word_valid), 32'd1);
        tick();
        checkOutput("reentryDrained", 32'(busM.words_avail), 32'd0);

        // Asynchronous reset between edges with buffered words
        busM.word_ready = 1'b0;
        applyStimulus(8'hC3, 8);
        applyStimulus(8'hE7, 8);
        applyStimulus(8'h99, 8);
        applyStimulus(8'hA0, 3);
        checkOutput("preRstAvail", 32'(busM.words_avail), 32'd2);
        checkOutput("preRstOverflow", 32'(busM.overflow), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(busM.word_valid), 32'd0);
        checkOutput("asyncAvail", 32'(busM.words_avail), 32'd0);
        checkOutput("asyncOverflow", 32'(busM.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        busM.word_ready = 1'b1;
        tick();
        expQ.push_back(8'h96);
        applyStimulus(8'h96, 8);
        checkOutput("postRstValid", 32'(busM.word_valid), 32'd1);
        tick();
        checkOutput("postRstDrained", 32'(busM.words_avail), 32'd0);

`ifdef BBS_PACKER_MONOBIT_EN
        // Monobit count: 32 bits with 17 ones, then cleared on restart
        busM.start = 1'b0;
        tick();
        busM.start = 1'b1;
        tick();
        expQ.push_back(8'hFF);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h01);
        expQ.push_back(8'h00);
        applyStimulus(8'hFF, 8);
        applyStimulus(8'hFF, 8);
        applyStimulus(8'h01, 8);
        applyStimulus(8'h00, 8);
        checkOutput("onesCount", 32'(busM.ones_count), 32'd17);
        tick();
        busM.start = 1'b0;
        tick();
        busM.start = 1'b1;
        tick();
        checkOutput("onesCleared", 32'(busM.ones_count), 32'd0);
`endif

        tick();
        tick();
        checkOutput("msbQueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("lsbQueueEmpty", 32'(expQL.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
